// File: rtl/pc_unit_if.sv
// Fetch-PC unit interface: control/branch side drives redirect requests,
// the PC unit returns the fetch address, EPC and status flags.
interface pc_unit_if #(
    parameter int unsigned ADDRESS_SIZE = 32
);
    logic                    stall;
    logic                    branch_taken;
    logic [ADDRESS_SIZE-1:0] branch_target;
    logic                    jump;
    logic [ADDRESS_SIZE-1:0] jump_target;
    logic                    exception;
    logic                    eret;
    logic                    ras_push;
    logic                    ras_pop;
    logic [ADDRESS_SIZE-1:0] pc;
    logic [ADDRESS_SIZE-1:0] pc_plus4;
    logic [ADDRESS_SIZE-1:0] epc;
    logic                    pc_valid;
    logic                    ras_empty;

    // Control/branch logic side
    modport master (
        output stall, branch_taken, branch_target, jump, jump_target,
               exception, eret, ras_push, ras_pop,
        input  pc, pc_plus4, epc, pc_valid, ras_empty
    );

    // PC unit side
    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_target,
               exception, eret, ras_push, ras_pop,
        output pc, pc_plus4, epc, pc_valid, ras_empty
    );
endinterface

// File: rtl/pc_unit.sv
// Fetch program-counter unit for the single-cycle MIPS core.
// Holds the fetch PC, a one-cycle boot state, the exception PC and,
// when the PC_RAS_EN macro is defined, a circular return-address stack.
// Next-PC priority in RUN: exception > eret > stall > branch > jump > pop > +4.
module pc_unit #(
    parameter int unsigned           ADDRESS_SIZE = 32,
    parameter logic [ADDRESS_SIZE-1:0] RESET_VECTOR = '0,
    parameter logic [ADDRESS_SIZE-1:0] EXC_VECTOR   = ADDRESS_SIZE'(32'h0000_0180),
    parameter int unsigned           RAS_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    pc_unit_if.slave    bus
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [ADDRESS_SIZE-1:0] align(input logic [ADDRESS_SIZE-1:0] a);
        return {a[ADDRESS_SIZE-1:2], 2'b00};
    endfunction

    localparam logic [ADDRESS_SIZE-1:0] RESET_PC = align(RESET_VECTOR);
    localparam logic [ADDRESS_SIZE-1:0] EXC_PC   = align(EXC_VECTOR);

    state_t                  state;
    logic [ADDRESS_SIZE-1:0] pc_r;
    logic [ADDRESS_SIZE-1:0] epc_r;
    logic                    pc_valid_r;
    logic [ADDRESS_SIZE-1:0] pc_plus4_w;
    logic [ADDRESS_SIZE-1:0] ras_top;
    logic                    ras_pop_en;
    logic                    ras_empty_w;

    assign pc_plus4_w = pc_r + ADDRESS_SIZE'(4);

`ifdef PC_RAS_EN
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

    logic [ADDRESS_SIZE-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]        ras_ptr;
    logic [PTR_W:0]          ras_count;
    logic                    ras_push_en;

    // Push is allowed alongside eret/branch/jump (jal); pop only redirects
    // when nothing of higher priority claims the PC and the stack has data.
    assign ras_push_en = (state == RUN) && !bus.stall && !bus.exception && bus.ras_push;
    assign ras_pop_en  = (state == RUN) && !bus.exception && !bus.eret && !bus.stall &&
                         !bus.branch_taken && !bus.jump && bus.ras_pop &&
                         (ras_count != '0);
    assign ras_top     = ras_mem[ras_ptr];
    assign ras_empty_w = (ras_count == '0);

    // Stack pointer/count update; a push onto a full stack overwrites the oldest entry
    always_ff @(posedge clk) begin
        if (reset) begin
            ras_ptr   <= '0;
            ras_count <= '0;
        end else if (ras_push_en && ras_pop_en) begin
            ras_mem[ras_ptr] <= pc_plus4_w;
        end else if (ras_push_en) begin
            ras_mem[ras_ptr + 1'b1] <= pc_plus4_w;
            ras_ptr                 <= ras_ptr + 1'b1;
            if (ras_count != (PTR_W + 1)'(RAS_DEPTH)) begin
                ras_count <= ras_count + 1'b1;
            end
        end else if (ras_pop_en) begin
            ras_ptr   <= ras_ptr - 1'b1;
            ras_count <= ras_count - 1'b1;
        end
    end
`else
    logic unused_ras;

    assign unused_ras  = bus.ras_push ^ bus.ras_pop;
    assign ras_pop_en  = 1'b0;
    assign ras_top     = '0;
    assign ras_empty_w = 1'b1;
`endif

    // Boot/run state machine with registered pc, epc and pc_valid
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BOOT;
            pc_r       <= RESET_PC;
            epc_r      <= '0;
            pc_valid_r <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state      <= RUN;
                    pc_r       <= RESET_PC;
                    pc_valid_r <= 1'b1;
                end
                RUN: begin
                    pc_valid_r <= 1'b1;
                    if (bus.exception) begin
                        epc_r <= pc_r;
                        pc_r  <= EXC_PC;
                    end else if (bus.eret) begin
                        pc_r <= align(epc_r);
                    end else if (bus.stall) begin
                        pc_r <= pc_r;
                    end else if (bus.branch_taken) begin
                        pc_r <= align(bus.branch_target);
                    end else if (bus.jump) begin
                        pc_r <= align(bus.jump_target);
                    end else if (ras_pop_en) begin
                        pc_r <= align(ras_top);
                    end else begin
                        pc_r <= pc_plus4_w;
                    end
                end
            endcase
        end
    end

    assign bus.pc        = pc_r;
    assign bus.pc_plus4  = pc_plus4_w;
    assign bus.epc       = epc_r;
    assign bus.pc_valid  = pc_valid_r;
    assign bus.ras_empty = ras_empty_w;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed test-plan sequences plus random stimulus,
// all checked every cycle against a queue-based reference model.
module tb_pc_unit;

`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic clk;
    logic reset;
    logic reset8;

    pc_unit_if #(.ADDRESS_SIZE(32)) bus ();
    pc_unit_if #(.ADDRESS_SIZE(8))  bus8 ();

    pc_unit #(.ADDRESS_SIZE(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pc_unit #(.ADDRESS_SIZE(8)) dut8 (
        .clk   (clk),
        .reset (reset8),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    bit          m_valid;
    bit          m_boot;
    logic [31:0] ras_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [31:0] p4;
        logic [31:0] nxt;
        bit          push_ok;
        bit          pop_ok;
        if (reset) begin
            m_pc    = 32'h0;
            m_epc   = 32'h0;
            m_valid = 1'b0;
            m_boot  = 1'b1;
            ras_q.delete();
        end else if (m_boot) begin
            m_boot  = 1'b0;
            m_valid = 1'b1;
        end else begin
            p4      = m_pc + 32'd4;
            push_ok = RAS_ON && bus.ras_push && !bus.stall && !bus.exception;
            pop_ok  = RAS_ON && bus.ras_pop && !bus.exception && !bus.eret && !bus.stall &&
                      !bus.branch_taken && !bus.jump && (ras_q.size() > 0);
            if (bus.exception) begin
                m_epc = m_pc;
                nxt   = 32'h180;
            end else if (bus.eret)         nxt = m_epc & ~32'h3;
            else if (bus.stall)            nxt = m_pc;
            else if (bus.branch_taken)     nxt = bus.branch_target & ~32'h3;
            else if (bus.jump)             nxt = bus.jump_target & ~32'h3;
            else if (pop_ok)               nxt = ras_q[ras_q.size() - 1] & ~32'h3;
            else                           nxt = p4;
            if (push_ok && pop_ok) begin
                ras_q[ras_q.size() - 1] = p4;
            end else if (push_ok) begin
                ras_q.push_back(p4);
                if (ras_q.size() > 4) void'(ras_q.pop_front());
            end else if (pop_ok) begin
                void'(ras_q.pop_back());
            end
            m_pc = nxt;
        end
    endtask

    task automatic compare_all();
        check("pc", bus.pc, m_pc);
        check("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
        check("epc", bus.epc, m_epc);
        check("pc_valid", 32'(bus.pc_valid), 32'(m_valid));
        check("ras_empty", 32'(bus.ras_empty), 32'(!RAS_ON || ras_q.size() == 0));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.jump          = 1'b0;
        bus.jump_target   = '0;
        bus.exception     = 1'b0;
        bus.eret          = 1'b0;
        bus.ras_push      = 1'b0;
        bus.ras_pop       = 1'b0;
    endtask

    initial begin
        bit found;
        idle();
        bus8.stall = 1'b0; bus8.branch_taken = 1'b0; bus8.branch_target = '0;
        bus8.jump = 1'b0; bus8.jump_target = '0; bus8.exception = 1'b0;
        bus8.eret = 1'b0; bus8.ras_push = 1'b0; bus8.ras_pop = 1'b0;
        reset  = 1'b1;
        reset8 = 1'b1;
        m_pc = '0; m_epc = '0; m_valid = 1'b0; m_boot = 1'b1;

        // Reset and boot
        step(); step();
        check("rst_pc", bus.pc, 32'h0);
        check("rst_valid", 32'(bus.pc_valid), 32'h0);
        check("rst_empty", 32'(bus.ras_empty), 32'h1);
        reset = 1'b0;
        check("boot_valid", 32'(bus.pc_valid), 32'h0);
        step();
        check("run_pc", bus.pc, 32'h0);
        check("run_valid", 32'(bus.pc_valid), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("seq_pc", bus.pc, 32'(4 * i));
        end

        // Stall, branch, jump
        bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h43;
        step(); check("stall_pc", bus.pc, 32'h10);
        bus.stall = 1'b0;
        step(); check("branch_pc", bus.pc, 32'h40);
        bus.branch_taken = 1'b0; bus.jump = 1'b1; bus.jump_target = 32'h100;
        step(); check("jump_pc", bus.pc, 32'h100);

        // Exception and return
        bus.jump_target = 32'h20;
        step();
        bus.jump = 1'b0;
        step(); check("pre_exc_pc", bus.pc, 32'h24);
        bus.exception = 1'b1; bus.stall = 1'b1;
        step(); check("exc_pc", bus.pc, 32'h180); check("exc_epc", bus.epc, 32'h24);
        idle();
        step(); step();
        bus.eret = 1'b1;
        step(); check("eret_pc", bus.pc, 32'h24);
        bus.exception = 1'b1;
        step(); check("exc_eret_pc", bus.pc, 32'h180);
        idle();

        if (RAS_ON) begin
            // Three jal-style pushes, then three pops and one on an empty stack
            bus.jump = 1'b1; bus.jump_target = 32'h10;
            step();
            bus.ras_push = 1'b1; bus.jump_target = 32'h20;
            step();
            bus.jump_target = 32'h30;
            step();
            bus.jump_target = 32'h200;
            step(); check("ras_jal_pc", bus.pc, 32'h200);
            check("ras_nonempty", 32'(bus.ras_empty), 32'h0);
            idle(); bus.ras_pop = 1'b1;
            step(); check("ras_pop0", bus.pc, 32'h34);
            step(); check("ras_pop1", bus.pc, 32'h24);
            step(); check("ras_pop2", bus.pc, 32'h14);
            check("ras_drained", 32'(bus.ras_empty), 32'h1);
            step(); check("ras_pop_empty", bus.pc, 32'h18);
            // Overflow: five pushes keep the newest four
            idle(); bus.ras_push = 1'b1;
            for (int i = 0; i < 5; i++) step();
            check("ras_push5_pc", bus.pc, 32'h2C);
            idle(); bus.ras_pop = 1'b1;
            step(); check("ras_ovf0", bus.pc, 32'h2C);
            step(); check("ras_ovf1", bus.pc, 32'h28);
            step(); check("ras_ovf2", bus.pc, 32'h24);
            step(); check("ras_ovf3", bus.pc, 32'h20);
            step(); check("ras_ovf4", bus.pc, 32'h24);
            idle();
        end

        // Reset mid-operation with stack entries and a saved epc
        bus.exception = 1'b1;
        step();
        idle(); bus.ras_push = 1'b1;
        step(); step();
        idle(); bus.jump = 1'b1; bus.jump_target = 32'h200;
        step(); check("mid_pc", bus.pc, 32'h200);
        idle(); reset = 1'b1;
        step();
        check("mid_rst_pc", bus.pc, 32'h0);
        check("mid_rst_empty", 32'(bus.ras_empty), 32'h1);
        check("mid_rst_epc", bus.epc, 32'h0);
        check("mid_rst_valid", 32'(bus.pc_valid), 32'h0);
        reset = 1'b0;

        // 8-bit wrap-around on the narrow instance
        reset8 = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (bus8.pc == 8'hFC) found = 1'b1;
        end
        check("wrap_reach", 32'(found), 32'h1);
        step();
        check("wrap_pc", 32'(bus8.pc), 32'h0);
        check("wrap_plus4", 32'(bus8.pc_plus4), 32'h4);

        // Random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            reset             = ($urandom_range(0, 99) == 0);
            bus.stall         = ($urandom_range(0, 7) == 0);
            bus.branch_taken  = ($urandom_range(0, 5) == 0);
            bus.branch_target = $urandom;
            bus.jump          = ($urandom_range(0, 7) == 0);
            bus.jump_target   = $urandom;
            bus.exception     = ($urandom_range(0, 19) == 0);
            bus.eret          = ($urandom_range(0, 14) == 0);
            bus.ras_push      = ($urandom_range(0, 3) == 0);
            bus.ras_pop       = ($urandom_range(0, 2) == 0);
            step();
        end
        reset = 1'b0;
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
